// File: rtl/rand_req_arbiter.sv
// Round-robin arbiter that shares one 4-bit game RNG among N_REQ clients and
// returns a range-limited draw (reject-and-retry, then fold-back) to the winner.
module rand_req_arbiter #(
  parameter int N_REQ     = 10,
  parameter int MAX_VAL   = 9,
  parameter int RETRY_MAX = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic [3:0]       rand_in,
  output logic [N_REQ-1:0] gen_en,
  output logic [N_REQ-1:0] grant,
  output logic [3:0]       rand_out,
  output logic             rand_valid,
  output logic             busy,
  output logic [7:0]       drop_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: req is a level request held by the client until it sees grant;
  // grant and rand_valid form a one-cycle pulse with no backpressure, and
  // rand_out stays stable from that pulse until the next grant.

  localparam int          IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0]  MAX4     = 4'(MAX_VAL);
  localparam logic [3:0]  FOLD4    = 4'(MAX_VAL + 1);
  localparam logic [2:0]  RETRY3   = 3'(RETRY_MAX);
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    SAMPLE = 2'd2,
    GRANT  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    sel, sel_nxt;
  logic [IW-1:0]    rr_last, rr_last_nxt;
  logic [2:0]       retry_cnt, retry_cnt_nxt;
  logic [3:0]       value, value_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic             rand_valid_nxt;
  logic [3:0]       rand_out_nxt;
  logic [7:0]       drop_cnt_nxt;
  logic [IW-1:0]    pick_idx;

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] s);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  // First set request bit searching upward, circularly, from last+1.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [IW-1:0]    last);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = last;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last) + i) % N_REQ;
      if (!found && r[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign pick_idx  = rr_pick(req, rr_last);
  assign gen_en    = (state == STEP) ? onehot(sel) : '0;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state      <= IDLE;
      sel        <= '0;
      rr_last    <= LAST_RST;
      retry_cnt  <= '0;
      value      <= '0;
      grant      <= '0;
      rand_out   <= '0;
      rand_valid <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      rr_last    <= rr_last_nxt;
      retry_cnt  <= retry_cnt_nxt;
      value      <= value_nxt;
      grant      <= grant_nxt;
      rand_out   <= rand_out_nxt;
      rand_valid <= rand_valid_nxt;
      drop_cnt   <= drop_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    rr_last_nxt    = rr_last;
    retry_cnt_nxt  = retry_cnt;
    value_nxt      = value;
    grant_nxt      = '0;
    rand_valid_nxt = 1'b0;
    rand_out_nxt   = rand_out;
    drop_cnt_nxt   = drop_cnt;

    case (state)
      IDLE: begin
        if (req != '0) begin
          sel_nxt       = pick_idx;
          retry_cnt_nxt = '0;
          state_nxt     = STEP;
        end
      end
      STEP: begin
        state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (rand_in <= MAX4) begin
          value_nxt = rand_in;
          state_nxt = GRANT;
        end else if (retry_cnt == RETRY3) begin
          // Out-of-range values are at most 15, so one subtraction lands in range.
          value_nxt = rand_in - FOLD4;
          state_nxt = GRANT;
        end else begin
          retry_cnt_nxt = retry_cnt + 3'd1;
          state_nxt     = STEP;
        end
      end
      GRANT: begin
        rr_last_nxt = sel;
        state_nxt   = IDLE;
        if (req[sel]) begin
          grant_nxt      = onehot(sel);
          rand_valid_nxt = 1'b1;
          rand_out_nxt   = value;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt_nxt = drop_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
